// File: rtl/random_grant_sched_if.sv
// rtl/random_grant_sched_if.sv - request/grant and tagged response channel bundle
interface random_grant_sched_if #(
  parameter int NUM   = 3,
  parameter int DSIZE = 8
);
  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

  logic [NUM-1:0]   req;
  logic [NUM-1:0]   gnt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DSIZE-1:0] rsp_data;
  logic [IW-1:0]    rsp_id;
  logic             busy;

  // Scheduler side: takes requests and the response accept, drives everything else.
  modport slave (
    input  req,
    input  rsp_ready,
    output gnt,
    output rsp_valid,
    output rsp_data,
    output rsp_id,
    output busy
  );

  // Consumer side: raises requests and accepts responses.
  modport master (
    output req,
    output rsp_ready,
    input  gnt,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id,
    input  busy
  );
endinterface

// File: rtl/random_grant_sched.sv
// rtl/random_grant_sched.sv - round-robin arbitrated, range-reduced LFSR draw scheduler
module random_grant_sched #(
  parameter int          NUM         = 3,
  parameter int          DSIZE       = 8,
  parameter int          BEGIN_VALUE = 0,
  parameter int          END_VALUE   = 100,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                clock,
  input  logic                rst_n,
  random_grant_sched_if.slave bus
);
  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
  // One extra bit so last + 1 + offset never overflows before the wrap.
  localparam int CW = IW + 1;
  // Wide enough to hold RANGE shifted by 15 without losing bits.
  localparam int WW = 16 + DSIZE + 1;
  localparam int RANGE = END_VALUE - BEGIN_VALUE + 1;

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]      TAPS     = 16'hB400;
  localparam logic [WW-1:0]    RANGE_W  = WW'(RANGE);
  localparam logic [DSIZE-1:0] BEGIN_D  = DSIZE'(BEGIN_VALUE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_REDUCE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [WW-1:0]    r_work;
  logic [3:0]       r_k;
  logic [IW-1:0]    r_id;
  logic [IW-1:0]    r_last;
  logic [NUM-1:0]   r_gnt;
  logic             r_rsp_valid;
  logic [DSIZE-1:0] r_rsp_data;
  logic [IW-1:0]    r_rsp_id;
  logic             r_busy;

  logic [15:0]      w_lfsr_next;
  logic [WW-1:0]    w_div;
  logic             w_ge;
  logic [WW-1:0]    w_work_next;
  logic             w_found;
  logic [IW-1:0]    w_sel_id;
  logic [CW-1:0]    w_cand;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);

  // One restoring-division step: subtract the shifted range when it fits.
  assign w_div       = RANGE_W << r_k;
  assign w_ge        = (r_work >= w_div);
  assign w_work_next = w_ge ? (r_work - w_div) : r_work;

  // Pick the first active request after the last served one, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_sel_id = '0;
    w_cand   = '0;
    for (int i = 0; i < NUM; i++) begin
      w_cand = CW'(r_last) + CW'(1) + CW'(i);
      if (w_cand >= CW'(NUM)) begin
        w_cand = w_cand - CW'(NUM);
      end
      if (!w_found && bus.req[w_cand[IW-1:0]]) begin
        w_found  = 1'b1;
        w_sel_id = w_cand[IW-1:0];
      end
    end
  end

  // Grant, step, reduce, deliver; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED_EFF;
      r_work      <= '0;
      r_k         <= '0;
      r_id        <= '0;
      r_last      <= IW'(NUM - 1);
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id    <= w_sel_id;
            r_gnt   <= NUM'(1) << w_sel_id;
            r_busy  <= 1'b1;
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_lfsr  <= w_lfsr_next;
          r_work  <= WW'(w_lfsr_next);
          r_k     <= 4'd15;
          r_state <= S_REDUCE;
        end
        S_REDUCE: begin
          r_work <= w_work_next;
          if (r_k == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_work_next[DSIZE-1:0] + BEGIN_D;
            r_rsp_id    <= r_id;
            r_state     <= S_OUT;
          end else begin
            r_k <= r_k - 4'd1;
          end
        end
        S_OUT: begin
          if (bus.rsp_ready) begin
            r_last      <= r_id;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_random_grant_sched.sv
// tb/tb_random_grant_sched.sv - scoreboard bench for random_grant_sched
module tb_random_grant_sched;
  localparam int NUM = 3;

  logic clock;
  logic rst_n;
  logic rst_n_b;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  random_grant_sched_if #(.NUM(3), .DSIZE(8)) bus_a ();
  random_grant_sched_if #(.NUM(1), .DSIZE(8)) bus_b ();
  random_grant_sched_if #(.NUM(1), .DSIZE(8)) bus_c ();

  random_grant_sched #(.NUM(3), .DSIZE(8), .BEGIN_VALUE(0), .END_VALUE(100), .SEED(16'hACE1))
    u_dut_a (.clock(clock), .rst_n(rst_n), .bus(bus_a));
  random_grant_sched #(.NUM(1), .DSIZE(8), .BEGIN_VALUE(10), .END_VALUE(12), .SEED(16'hACE1))
    u_dut_b (.clock(clock), .rst_n(rst_n_b), .bus(bus_b));
  random_grant_sched #(.NUM(1), .DSIZE(8), .BEGIN_VALUE(20), .END_VALUE(20), .SEED(16'hACE1))
    u_dut_c (.clock(clock), .rst_n(rst_n_b), .bus(bus_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_id[$];
  int          acc_data[$];
  int          acc_cyc[$];
  logic [15:0] m_lfsr;
  int          m_last;
  bit          m_busy;
  bit          was_idle;
  bit          prev_valid;
  int          prev_data;
  int          prev_id;
  int          cyc_a = 0;
  int          gnt_cyc = 0;
  int          sel;
  bit          found;
  int          cand;
  logic [2:0]  exp_g;
  exp_t        e;

  // Scoreboard for the 3-requester instance: predict grants, push draws, pop on accept.
  always @(posedge clock) begin
    #1;
    cyc_a++;
    if (!rst_n) begin
      m_lfsr     = 16'hACE1;
      m_last     = NUM - 1;
      m_busy     = 1'b0;
      prev_valid = 1'b0;
      exp_q.delete();
    end else begin
      was_idle = !m_busy;
      if (prev_valid && bus_a.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("a_unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("a_rsp_id", prev_id, e.id);
          chk_eq("a_rsp_data", prev_data, e.data);
        end
        acc_id.push_back(prev_id);
        acc_data.push_back(prev_data);
        acc_cyc.push_back(cyc_a);
        m_last = prev_id;
        m_busy = 1'b0;
        chk_eq("a_valid_drop", bus_a.rsp_valid, 0);
      end else if (prev_valid) begin
        chk_eq("a_hold_valid", bus_a.rsp_valid, 1);
        chk_eq("a_hold_data", bus_a.rsp_data, prev_data);
        chk_eq("a_hold_id", bus_a.rsp_id, prev_id);
      end
      exp_g = 3'b000;
      found = 1'b0;
      sel   = 0;
      if (was_idle && bus_a.req != 3'b000) begin
        for (int i = 1; i <= NUM; i++) begin
          cand = (m_last + i) % NUM;
          if (!found && bus_a.req[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
        exp_g = 3'b001 << sel;
      end
      chk_eq("a_gnt", bus_a.gnt, exp_g);
      if (found) begin
        m_lfsr = lfsr_step(m_lfsr);
        exp_q.push_back('{sel, int'(m_lfsr) % 101});
        m_busy  = 1'b1;
        gnt_cyc = cyc_a;
      end
      chk_eq("a_busy", bus_a.busy, m_busy);
      if (bus_a.rsp_valid && !prev_valid) begin
        chk_eq("a_latency", cyc_a - gnt_cyc, 17);
      end
      prev_valid = bus_a.rsp_valid;
      prev_data  = bus_a.rsp_data;
      prev_id    = bus_a.rsp_id;
    end
  end

  logic [15:0] mb_lfsr = 16'hACE1;
  int          n_b = 0;
  int          n_c = 0;

  // Range checks on the single-requester instances; ready is always high so each valid is one beat.
  always @(posedge clock) begin
    #1;
    if (rst_n_b) begin
      if (bus_b.rsp_valid) begin
        mb_lfsr = lfsr_step(mb_lfsr);
        chk_eq("b_data", bus_b.rsp_data, 10 + int'(mb_lfsr) % 3);
        chk_eq("b_range", (bus_b.rsp_data >= 8'd10 && bus_b.rsp_data <= 8'd12), 1);
        chk_eq("b_id", bus_b.rsp_id, 0);
        if (n_b == 0) chk_eq("b_first", bus_b.rsp_data, 12);
        n_b++;
      end
      if (bus_c.rsp_valid) begin
        chk_eq("c_data", bus_c.rsp_data, 20);
        n_c++;
      end
    end
  end

  task automatic wait_acc(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (acc_id.size() < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk_eq(tag, acc_id.size(), target);
  endtask

  task automatic clear_acc();
    acc_id.delete();
    acc_data.delete();
    acc_cyc.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    clear_acc();
  endtask

  initial begin
    int n;
    rst_n            = 1'b0;
    rst_n_b          = 1'b0;
    bus_a.req        = 3'b000;
    bus_a.rsp_ready  = 1'b0;
    bus_b.req        = 1'b0;
    bus_b.rsp_ready  = 1'b0;
    bus_c.req        = 1'b0;
    bus_c.rsp_ready  = 1'b0;
    repeat (3) @(negedge clock);
    chk_eq("rst_gnt", bus_a.gnt, 0);
    chk_eq("rst_valid", bus_a.rsp_valid, 0);
    chk_eq("rst_data", bus_a.rsp_data, 0);
    chk_eq("rst_id", bus_a.rsp_id, 0);
    chk_eq("rst_busy", bus_a.busy, 0);

    // Single requester 0, back-to-back draws.
    rst_n           = 1'b1;
    rst_n_b         = 1'b1;
    bus_b.req       = 1'b1;
    bus_b.rsp_ready = 1'b1;
    bus_c.req       = 1'b1;
    bus_c.rsp_ready = 1'b1;
    bus_a.req       = 3'b001;
    bus_a.rsp_ready = 1'b1;
    wait_acc("p1_count", 2, 100);
    if (acc_id.size() >= 2) begin
      chk_eq("p1_data0", acc_data[0], 95);
      chk_eq("p1_data1", acc_data[1], 98);
      chk_eq("p1_id0", acc_id[0], 0);
      chk_eq("p1_id1", acc_id[1], 0);
      chk_eq("p1_spacing", acc_cyc[1] - acc_cyc[0], 19);
    end

    // All three requesting: round-robin order from a fresh reset.
    pulse_reset();
    bus_a.req = 3'b111;
    wait_acc("p2_count", 4, 150);
    if (acc_id.size() >= 4) begin
      chk_eq("p2_id0", acc_id[0], 0);
      chk_eq("p2_id1", acc_id[1], 1);
      chk_eq("p2_id2", acc_id[2], 2);
      chk_eq("p2_id3", acc_id[3], 0);
    end

    // Back-pressure: response held for 10 cycles, stability checked by the scoreboard.
    bus_a.rsp_ready = 1'b0;
    n = 0;
    while (!bus_a.rsp_valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk_eq("p3_valid_seen", bus_a.rsp_valid, 1);
    repeat (10) @(negedge clock);
    chk_eq("p3_still_valid", bus_a.rsp_valid, 1);
    chk_eq("p3_no_accept", acc_id.size(), 4);
    bus_a.rsp_ready = 1'b1;
    wait_acc("p3_count", 5, 5);
    if (acc_id.size() >= 5) chk_eq("p3_id", acc_id[4], 1);

    // Reset during REDUCE, then a request that is dropped right after its grant.
    pulse_reset();
    bus_a.req = 3'b001;
    n = 0;
    while (!bus_a.busy && n < 10) begin
      @(negedge clock);
      n++;
    end
    repeat (5) @(negedge clock);
    bus_a.req = 3'b010;
    rst_n     = 1'b0;
    @(negedge clock);
    chk_eq("p4_rst_valid", bus_a.rsp_valid, 0);
    chk_eq("p4_rst_busy", bus_a.busy, 0);
    chk_eq("p4_no_rsp", acc_id.size(), 0);
    rst_n = 1'b1;
    n = 0;
    while (!bus_a.busy && n < 10) begin
      @(negedge clock);
      n++;
    end
    bus_a.req = 3'b000;
    wait_acc("p4_count", 1, 60);
    if (acc_id.size() >= 1) begin
      chk_eq("p4_data", acc_data[0], 95);
      chk_eq("p4_id", acc_id[0], 1);
    end

    // Let the narrow-range instances complete 1000 draws.
    n = 0;
    while (n_b < 1000 && n < 25000) begin
      @(negedge clock);
      n++;
    end
    chk_eq("b_draws", (n_b >= 1000), 1);
    chk_eq("c_draws", (n_c >= 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
